// File: rtl/prog_tick_divider.sv
// Programmable tick divider: one-cycle tick every div_active enabled cycles, with a
// deferred divisor load. Optional square-wave output under PROG_TICK_DIVIDER_SQUARE_EN.
module prog_tick_divider #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sync_clr,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_in,
  output logic             tick,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] div_active,
  output logic             load_pending
`ifdef PROG_TICK_DIVIDER_SQUARE_EN
  ,
  output logic             sq_out
`endif
);

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_active_q, div_active_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             load_pending_q, load_pending_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] din_clamp_s;
  logic             tc_s;
  logic             apply_s;

  // Next-state logic: counting, tick generation and divisor hand-over at period boundaries
  always_comb begin
    count_d        = count_q;
    div_active_d   = div_active_q;
    pend_d         = pend_q;
    load_pending_d = load_pending_q;
    tick_d         = 1'b0;
    din_clamp_s    = (div_in == ZERO) ? ONE : div_in;
    tc_s           = enable && (count_q == (div_active_q - ONE));
    apply_s        = sync_clr || tc_s;

    if (sync_clr) begin
      count_d = ZERO;
    end else if (enable) begin
      count_d = tc_s ? ZERO : (count_q + ONE);
      tick_d  = tc_s;
    end else begin
      count_d = count_q;
    end

    // A divisor only takes effect at a period boundary so div_active never shifts mid-period
    if (apply_s) begin
      if (div_load) begin
        div_active_d = din_clamp_s;
        pend_d       = din_clamp_s;
      end else if (load_pending_q) begin
        div_active_d = pend_q;
      end else begin
        div_active_d = div_active_q;
      end
      load_pending_d = 1'b0;
    end else if (div_load) begin
      pend_d         = din_clamp_s;
      load_pending_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q        <= ZERO;
      div_active_q   <= RST_DIV;
      pend_q         <= RST_DIV;
      load_pending_q <= 1'b0;
      tick_q         <= 1'b0;
    end else begin
      count_q        <= count_d;
      div_active_q   <= div_active_d;
      pend_q         <= pend_d;
      load_pending_q <= load_pending_d;
      tick_q         <= tick_d;
    end
  end

  assign tick         = tick_q;
  assign count        = count_q;
  assign div_active   = div_active_q;
  assign load_pending = load_pending_q;

`ifdef PROG_TICK_DIVIDER_SQUARE_EN
  logic             sq_q, sq_d;
  logic [WIDTH:0]   half_s;

  // High while the upcoming count sits in the first ceil(N/2) phases; widened to avoid overflow
  always_comb begin
    sq_d   = sq_q;
    half_s = ({1'b0, div_active_d} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    if (sync_clr || enable) begin
      sq_d = ({1'b0, count_d} < half_s);
    end else begin
      sq_d = sq_q;
    end
  end

  // Square-wave register
  always_ff @(posedge clk) begin
    if (reset) begin
      sq_q <= 1'b1;
    end else begin
      sq_q <= sq_d;
    end
  end

  assign sq_out = sq_q;
`endif

endmodule

// File: tb/tb_prog_tick_divider.sv
// Randomized and directed self-checking bench for prog_tick_divider against an
// arithmetic reference model (phase modulo N, pending divisor slot).
module tb_prog_tick_divider;
  localparam int WIDTH     = 8;
  localparam int RESET_DIV = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             sync_clr = 1'b0;
  logic             div_load = 1'b0;
  logic [WIDTH-1:0] div_in = '0;
  logic             tick;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] div_active;
  logic             load_pending;
`ifdef PROG_TICK_DIVIDER_SQUARE_EN
  logic             sq_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_phase = 0;
  int m_n     = RESET_DIV;
  int m_pend  = RESET_DIV;
  int m_pf    = 0;
  int m_tick  = 0;
  int m_sq    = 1;

  prog_tick_divider #(.WIDTH(WIDTH), .RESET_DIV(RESET_DIV)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sync_clr     (sync_clr),
    .div_load     (div_load),
    .div_in       (div_in),
    .tick         (tick),
    .count        (count),
    .div_active   (div_active),
    .load_pending (load_pending)
`ifdef PROG_TICK_DIVIDER_SQUARE_EN
    ,
    .sq_out       (sq_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    int dinc;
    int wrap;
    dinc = (int'(div_in) == 0) ? 1 : int'(div_in);
    if (reset) begin
      m_phase = 0; m_tick = 0; m_n = RESET_DIV; m_pend = RESET_DIV; m_pf = 0; m_sq = 1;
    end else if (sync_clr) begin
      m_phase = 0; m_tick = 0;
      if (div_load) m_n = dinc;
      else if (m_pf != 0) m_n = m_pend;
      m_pf = 0;
      m_sq = 1;
    end else if (enable) begin
      wrap    = ((m_phase + 1) % m_n == 0) ? 1 : 0;
      m_tick  = wrap;
      m_phase = (m_phase + 1) % m_n;
      if (wrap != 0) begin
        if (div_load) m_n = dinc;
        else if (m_pf != 0) m_n = m_pend;
        m_pf = 0;
      end else if (div_load) begin
        m_pend = dinc; m_pf = 1;
      end
      m_sq = (m_phase < (m_n + 1) / 2) ? 1 : 0;
    end else begin
      m_tick = 0;
      if (div_load) begin
        m_pend = dinc; m_pf = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("count", 32'(count), 32'(m_phase));
    check("tick", 32'(tick), 32'(m_tick));
    check("div_active", 32'(div_active), 32'(m_n));
    check("load_pending", 32'(load_pending), 32'(m_pf));
`ifdef PROG_TICK_DIVIDER_SQUARE_EN
    check("sq_out", 32'(sq_out), 32'(m_sq));
`endif
  endtask

  task automatic idle_inputs();
    reset = 1'b0; sync_clr = 1'b0; div_load = 1'b0; div_in = '0;
  endtask

  initial begin
    // Reset, with a load and enable present to show reset wins
    reset = 1'b1; enable = 1'b1; div_load = 1'b1; div_in = 8'd9;
    step();
    step();
    check("rst_count", 32'(count), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_div", 32'(div_active), 32'd4);
    check("rst_lp", 32'(load_pending), 32'd0);
    idle_inputs();

    // Ticks on cycles 4, 8, 12 after release; count 1,2,3,0
    for (int c = 1; c <= 12; c++) begin
      step();
      check("r030_tick", 32'(tick), (c % 4 == 0) ? 32'd1 : 32'd0);
      check("r030_count", 32'(count), 32'(c % 4));
    end

    // Deferred load of 6 issued with count==1
    step();
    div_load = 1'b1; div_in = 8'd6;
    step();
    idle_inputs();
    check("r031_lp_set", 32'(load_pending), 32'd1);
    check("r031_div_old", 32'(div_active), 32'd4);
    step();
    check("r031_lp_hold", 32'(load_pending), 32'd1);
    step();
    check("r031_applied", 32'(div_active), 32'd6);
    check("r031_lp_clr", 32'(load_pending), 32'd0);
    check("r031_tick", 32'(tick), 32'd1);
    for (int c = 1; c <= 6; c++) begin
      step();
      check("r031_period", 32'(tick), (c == 6) ? 32'd1 : 32'd0);
    end

    // Divisor 0 clamps to 1: tick every enabled cycle
    sync_clr = 1'b1; div_load = 1'b1; div_in = 8'd0;
    step();
    idle_inputs();
    check("r032_div", 32'(div_active), 32'd1);
    for (int c = 0; c < 3; c++) begin
      step();
      check("r032_tick", 32'(tick), 32'd1);
      check("r032_count", 32'(count), 32'd0);
    end

    // Enable low holds count; tick follows 2 cycles after re-enable
    sync_clr = 1'b1; div_load = 1'b1; div_in = 8'd4;
    step();
    idle_inputs();
    step();
    step();
    check("r033_count2", 32'(count), 32'd2);
    enable = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      check("r033_hold", 32'(count), 32'd2);
      check("r033_notick", 32'(tick), 32'd0);
    end
    enable = 1'b1;
    step();
    check("r033_t1", 32'(tick), 32'd0);
    step();
    check("r033_t2", 32'(tick), 32'd1);

    // sync_clr with TC and load of 3
    step();
    step();
    step();
    check("r034_at_tc", 32'(count), 32'd3);
    sync_clr = 1'b1; div_load = 1'b1; div_in = 8'd3;
    step();
    idle_inputs();
    check("r034_tick", 32'(tick), 32'd0);
    check("r034_count", 32'(count), 32'd0);
    check("r034_div", 32'(div_active), 32'd3);
    check("r034_lp", 32'(load_pending), 32'd0);

    // Reset mid-period discards a pending load
    step();
    div_load = 1'b1; div_in = 8'd7;
    step();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("r027_lp", 32'(load_pending), 32'd0);
    check("r027_div", 32'(div_active), 32'd4);

    // Square wave with N=5 (model checks sq_out each step when compiled in)
    sync_clr = 1'b1; div_load = 1'b1; div_in = 8'd5;
    step();
    idle_inputs();
    for (int c = 0; c < 15; c++) step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 199) == 0);
      enable   = ($urandom_range(0, 3) != 0);
      sync_clr = ($urandom_range(0, 31) == 0);
      div_load = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 15) == 0) div_in = WIDTH'($urandom_range(0, 255));
      else div_in = WIDTH'($urandom_range(0, 9));
      step();
    end
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/prog_tick_divider.md
PROG_TICK_DIVIDER -- requirements
Module: prog_tick_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the bit width of the divisor and counter (legal 2..16).
REQ-002 SHALL have parameter RESET_DIV, default 4, the divisor active after reset (legal 1..2^WIDTH-1).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port enable, input, 1; when high the counter advances one step per cycle.
REQ-006 SHALL have port sync_clr, input, 1; restarts the count phase.
REQ-007 SHALL have port div_load, input, 1, a one-cycle strobe that captures div_in.
REQ-008 SHALL have port div_in, input, WIDTH, the requested divisor N.
REQ-009 SHALL have port tick, output, 1, a registered one-cycle pulse once per N enabled cycles.
REQ-010 SHALL have port count, output, WIDTH, the current phase counter value.
REQ-011 SHALL have port div_active, output, WIDTH, the divisor currently in use.
REQ-012 SHALL have port load_pending, output, 1; high while a captured divisor awaits application.
REQ-013 SHALL have port sq_out, output, 1, a square-wave output; present only per REQ-029.

Function
REQ-014 SHALL count 0 up to div_active-1, then wrap to 0 (the terminal count, TC).
REQ-015 SHALL register tick high for exactly the one cycle after an enabled TC, coinciding with count==0, giving period div_active enabled cycles.
REQ-016 SHALL, with enable low, hold count, hold sq_out, and drive tick 0.
REQ-017 SHALL clamp a div_in of 0 to 1 at capture; div_active==1 makes tick high on every enabled cycle while count stays 0.
REQ-018 SHALL store div_in on div_load in a pending register and set load_pending.
REQ-019 SHALL apply a pending divisor only at an enabled TC or at sync_clr: it copies to div_active and clears load_pending in that same edge. div_active never changes mid-period.
REQ-020 SHALL, for div_load coincident with an enabled TC or sync_clr, apply the new div_in directly at that edge and leave load_pending 0.
REQ-021 SHALL, for a second div_load while pending, overwrite the pending value (newest wins).
REQ-022 SHALL, on sync_clr, set count to 0 and tick to 0 regardless of enable; sync_clr takes priority over counting.
REQ-023 SHALL, for sync_clr and an enabled TC in the same cycle, follow sync_clr behaviour with no tick.
REQ-024 SHALL compare the counter as unsigned WIDTH-bit values, with no overflow for any legal divisor.

Reset
REQ-025 SHALL on reset set count=0, tick=0, div_active=RESET_DIV, pending register=RESET_DIV, load_pending=0, sq_out=1.
REQ-026 SHALL let reset override every other input, including a div_load or TC in the same cycle.
REQ-027 SHALL restart the count and lose any pending load when reset is asserted mid-period.
REQ-028 SHALL begin counting on the first enabled cycle after reset deasserts.

Configuration
REQ-029 SHALL compile sq_out and its logic only when macro PROG_TICK_DIVIDER_SQUARE_EN is defined. Registered behaviour: sq_out=1 while next count < ceil(div_active/2), else 0, so high for ceil(N/2) and low for floor(N/2) cycles; constant 1 for N=1. Without the macro the port and logic are absent and all other behaviour is identical.

Verification
REQ-030 SHALL cover: reset, enable=1, RESET_DIV=4 -> tick on cycles 4,8,12 after reset release; count sequence 1,2,3,0.
REQ-031 SHALL cover: div_load of div_in=6 with count=1 under N=4 -> load_pending=1 until the next TC, then period 6 and div_active=6.
REQ-032 SHALL cover: div_in=0 loaded -> div_active=1 and tick high every enabled cycle.
REQ-033 SHALL cover: enable low for 5 cycles with count=2 -> count holds 2, tick 0; after enable returns, tick follows 2 cycles later (N=4).
REQ-034 SHALL cover: sync_clr together with TC and div_load of div_in=3 -> no tick, count=0, div_active=3, load_pending=0.
REQ-035 SHALL cover: with PROG_TICK_DIVIDER_SQUARE_EN defined and N=5 -> sq_out high 3 cycles and low 2, repeating.
